// File: rtl/m_mem_stage.sv
// Memory pipeline stage: M pipeline register, req/ack data-bus FSM, store lane
// generation, load extension, address exception detection and M forwarding tuple.
module m_mem_stage #(
    parameter logic [31:0] MEM_TOP = 32'h0000_2FFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Reg_Rst,
    input  logic        We,
    input  logic [31:0] IR_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] Y_in,
    input  logic [31:0] V2_in,
    input  logic [4:0]  W_RFA3_in,
    input  logic [31:0] W_RFWD_in,
    input  logic        W_RFWr_in,
    input  logic        W_Forward_Ready_in,
    input  logic        DAck,
    input  logic [31:0] DRData,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DByteEn,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic [31:0] Y_out,
    output logic [31:0] LoadData_out,
    output logic        AdEL_out,
    output logic        AdES_out,
    output logic        Busy_out,
    output logic [4:0]  M_RFA3_out,
    output logic [31:0] M_RFWD_out,
    output logic        M_RFWr_out,
    output logic        M_Forward_Ready_out
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {A3_ZERO, A3_RT, A3_RD, A3_RA} a3_sel_t;
    typedef enum logic [1:0] {WD_ALU, WD_MEM, WD_PC8} wd_sel_t;

    state_t      state, state_next;
    logic [31:0] v2_p0;
    logic [31:0] rdata_p0;
    logic [31:0] v2_fwd;
    logic        mem_op, load_op, store_op, legal;
    logic        rfwr;
    a3_sel_t     a3_sel;
    wd_sel_t     wd_sel;

    function automatic logic is_mem(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Access width is encoded in op[1:0]: 00 byte, 01 half, 11 word.
    function automatic logic access_legal(input logic [5:0] op, input logic [31:0] addr);
        logic        aligned;
        logic [32:0] last;
        case (op[1:0])
            2'b11: begin
                aligned = (addr[1:0] == 2'b00);
                last    = {1'b0, addr} + 33'd3;
            end
            2'b01: begin
                aligned = ~addr[0];
                last    = {1'b0, addr} + 33'd1;
            end
            default: begin
                aligned = 1'b1;
                last    = {1'b0, addr};
            end
        endcase
        return aligned && (last <= {1'b0, MEM_TOP});
    endfunction

    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [31:0] word,
                                                input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   r = b;
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = h;
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] v2);
        case (op)
            OP_SH:   return {2{v2[15:0]}};
            OP_SB:   return {4{v2[7:0]}};
            default: return v2;
        endcase
    endfunction

    function automatic logic [3:0] store_byteen(input logic [5:0] op, input logic [1:0] lane);
        case (op)
            OP_SH:   return lane[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    assign mem_op   = is_mem(IR_out[31:26]);
    assign load_op  = mem_op && !IR_out[29];
    assign store_op = mem_op && IR_out[29];
    assign legal    = access_legal(IR_out[31:26], Y_out);
    assign Busy_out = mem_op && (state != DONE);

    // Instruction decode of the M-level instruction
    always_comb begin
        rfwr   = 1'b0;
        a3_sel = A3_ZERO;
        wd_sel = WD_ALU;
        case (IR_out[31:26])
            OP_RTYPE: begin
                if (IR_out[5:0] != FN_JR && IR_out != 32'd0) begin
                    rfwr   = 1'b1;
                    a3_sel = A3_RD;
                end
            end
            OP_JAL: begin
                rfwr   = 1'b1;
                a3_sel = A3_RA;
                wd_sel = WD_PC8;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                rfwr   = 1'b1;
                a3_sel = A3_RT;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                rfwr   = 1'b1;
                a3_sel = A3_RT;
                wd_sel = WD_MEM;
            end
            default: ;
        endcase
    end

    // Store data may depend on a W-level result that has not reached the register file
    assign v2_fwd = (IR_out[20:16] != 5'd0 && IR_out[20:16] == W_RFA3_in &&
                     W_RFWr_in && W_Forward_Ready_in) ? W_RFWD_in : v2_p0;

    // ---- M pipeline register ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            IR_out   <= 32'd0;
            PC_out   <= 32'd0;
            Y_out    <= 32'd0;
            v2_p0    <= 32'd0;
            rdata_p0 <= 32'd0;
        end else if (!Busy_out) begin
            if (Reg_Rst) begin
                IR_out <= 32'd0;
                PC_out <= 32'd0;
                Y_out  <= 32'd0;
                v2_p0  <= 32'd0;
            end else if (We) begin
                IR_out <= IR_in;
                PC_out <= PC_in;
                Y_out  <= Y_in;
                v2_p0  <= V2_in;
            end
        end else if (state == REQ) begin
            // Freeze the forwarded value so DWData cannot drift once W moves on
            v2_p0 <= v2_fwd;
            if (DAck) rdata_p0 <= DRData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!Busy_out) begin
            if (Reg_Rst)
                state_next = IDLE;
            else if (We) begin
                if (!is_mem(IR_in[31:26]))
                    state_next = IDLE;
                else if (access_legal(IR_in[31:26], Y_in))
                    state_next = REQ;
                else
                    state_next = DONE;
            end
        end else if (state == REQ && DAck) begin
            state_next = DONE;
        end
    end

    // ---- data bus and W-facing outputs ----
    assign DReq    = (state == REQ);
    assign DWe     = DReq && store_op;
    assign DAddr   = Y_out;
    assign DWData  = store_data(IR_out[31:26], v2_fwd);
    assign DByteEn = store_op ? store_byteen(IR_out[31:26], Y_out[1:0]) : 4'b1111;

    assign LoadData_out = load_op ? load_extend(IR_out[31:26], rdata_p0, Y_out[1:0]) : rdata_p0;
    assign AdEL_out     = load_op && !legal;
    assign AdES_out     = store_op && !legal;

    always_comb begin
        M_RFA3_out = 5'd0;
        case (a3_sel)
            A3_RT:   M_RFA3_out = IR_out[20:16];
            A3_RD:   M_RFA3_out = IR_out[15:11];
            A3_RA:   M_RFA3_out = 5'd31;
            default: M_RFA3_out = 5'd0;
        endcase
    end

    always_comb begin
        M_RFWD_out = Y_out;
        case (wd_sel)
            WD_PC8:  M_RFWD_out = PC_out + 32'd8;
            WD_MEM:  M_RFWD_out = LoadData_out;
            default: M_RFWD_out = Y_out;
        endcase
    end

    assign M_RFWr_out          = rfwr && !AdEL_out;
    assign M_Forward_Ready_out = !load_op || (state == DONE);

endmodule

// File: tb/tb_m_mem_stage.sv
// Randomized scoreboard bench for m_mem_stage: the driver pushes expected bus
// requests and retirement results; a negedge monitor pops and compares them.
module tb_m_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst, Reg_Rst, We;
    logic [31:0] IR_in, PC_in, Y_in, V2_in;
    logic [4:0]  W_RFA3_in;
    logic [31:0] W_RFWD_in;
    logic        W_RFWr_in, W_Forward_Ready_in;
    logic        DAck;
    logic [31:0] DRData;
    logic        DReq, DWe;
    logic [31:0] DAddr, DWData;
    logic [3:0]  DByteEn;
    logic [31:0] IR_out, PC_out, Y_out, LoadData_out;
    logic        AdEL_out, AdES_out, Busy_out;
    logic [4:0]  M_RFA3_out;
    logic [31:0] M_RFWD_out;
    logic        M_RFWr_out, M_Forward_Ready_out;

    always #5 Clk = ~Clk;

    m_mem_stage #(.MEM_TOP(32'h0000_2FFF)) dut (
        .Clk(Clk), .Rst(Rst), .Reg_Rst(Reg_Rst), .We(We),
        .IR_in(IR_in), .PC_in(PC_in), .Y_in(Y_in), .V2_in(V2_in),
        .W_RFA3_in(W_RFA3_in), .W_RFWD_in(W_RFWD_in), .W_RFWr_in(W_RFWr_in),
        .W_Forward_Ready_in(W_Forward_Ready_in),
        .DAck(DAck), .DRData(DRData),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DByteEn(DByteEn),
        .IR_out(IR_out), .PC_out(PC_out), .Y_out(Y_out), .LoadData_out(LoadData_out),
        .AdEL_out(AdEL_out), .AdES_out(AdES_out), .Busy_out(Busy_out),
        .M_RFA3_out(M_RFA3_out), .M_RFWD_out(M_RFWD_out), .M_RFWr_out(M_RFWr_out),
        .M_Forward_Ready_out(M_Forward_Ready_out)
    );

    typedef enum int {K_LW, K_LH, K_LHU, K_LB, K_LBU, K_SW, K_SH, K_SB, K_ADDU, K_ORI, K_JAL} kind_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        int          cycles;
    } bus_exp_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] load_data;
        logic [31:0] rfwd;
        logic        adel, ades, rfwr;
        logic [4:0]  rfa3;
        bit          chk_data, chk_wd, chk_ready;
        int          busy_cycles;
    } res_exp_t;

    int          checks = 0;
    int          errors = 0;
    bus_exp_t    bus_q[$];
    res_exp_t    res_q[$];
    logic [31:0] pc_next = 32'h0000_0400;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input kind_t k);
        case (k)
            K_LW, K_SW:        return 4;
            K_LH, K_LHU, K_SH: return 2;
            K_LB, K_LBU, K_SB: return 1;
            default:           return 0;
        endcase
    endfunction

    function automatic bit is_load(input kind_t k);
        return k inside {K_LW, K_LH, K_LHU, K_LB, K_LBU};
    endfunction

    function automatic bit is_store(input kind_t k);
        return k inside {K_SW, K_SH, K_SB};
    endfunction

    function automatic logic [31:0] make_ir(input kind_t k, input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm);
        logic [5:0] op;
        case (k)
            K_LW: op = 6'b100011;  K_LH: op = 6'b100001;  K_LHU: op = 6'b100101;
            K_LB: op = 6'b100000;  K_LBU: op = 6'b100100; K_SW: op = 6'b101011;
            K_SH: op = 6'b101001;  K_SB: op = 6'b101000;  K_ORI: op = 6'b001101;
            default: op = 6'b000000;
        endcase
        if (k == K_ADDU) return {6'b000000, 5'd1, rt, rd, 5'd0, 6'b100001};
        if (k == K_JAL)  return {6'b000011, 26'h10};
        return {op, 5'd1, rt, imm};
    endfunction

    function automatic bit legal_access(input int size, input logic [31:0] addr);
        return (addr % size == 0) && (longint'(addr) + size - 1 <= 64'h2FFF);
    endfunction

    // ---------------- stimulus ----------------
    task automatic do_op(input kind_t k, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] v2, input logic [31:0] word,
                         input int d, input logic [4:0] wa3, input logic [31:0] wwd,
                         input logic wwr, input logic wrdy);
        bus_exp_t    b;
        res_exp_t    r;
        int          size;
        bit          mem, lg;
        logic [31:0] pc, ir, v2eff, base;
        longint      v;
        size  = size_of(k);
        mem   = (size != 0);
        lg    = mem && legal_access(size, addr);
        pc    = pc_next;
        pc_next += 4;
        ir    = make_ir(k, rt, rd, addr[15:0]);
        v2eff = (rt != 0 && wa3 == rt && wwr && wrdy) ? wwd : v2;

        if (lg) begin
            b.addr   = addr;
            b.we     = is_store(k);
            b.cycles = d + 1;
            b.be     = 4'b0000;
            b.wdata  = 32'd0;
            base     = addr & ~32'd3;
            for (int i = 0; i < 4; i++) begin
                b.be[i] = ((base + i) >= addr) && ((base + i) < addr + size);
                b.wdata |= ((v2eff >> (8 * (i % size))) & 32'hFF) << (8 * i);
            end
            bus_q.push_back(b);
        end

        v = 0;
        if (is_load(k)) begin
            for (int i = 0; i < size; i++)
                v |= longint'((word >> (8 * ((addr % 4) + i))) & 32'hFF) << (8 * i);
            if ((k == K_LB || k == K_LH) && ((v >> (8 * size - 1)) & 1) == 1)
                v -= longint'(1) << (8 * size);
        end
        r.ir          = ir;
        r.load_data   = 32'(v);
        r.adel        = is_load(k) && !lg;
        r.ades        = is_store(k) && !lg;
        r.rfwr        = (is_load(k) && lg) || k inside {K_ADDU, K_ORI, K_JAL};
        r.rfa3        = (is_load(k) || k == K_ORI) ? rt : (k == K_ADDU) ? rd : (k == K_JAL) ? 5'd31 : 5'd0;
        r.rfwd        = (k == K_JAL) ? pc + 8 : is_load(k) ? r.load_data : addr;
        r.chk_data    = is_load(k) && lg;
        r.chk_wd      = !is_store(k) && !r.adel;
        r.chk_ready   = !is_store(k);
        r.busy_cycles = lg ? d + 1 : 0;
        res_q.push_back(r);

        IR_in = ir; PC_in = pc; Y_in = addr; V2_in = v2;
        W_RFA3_in = wa3; W_RFWD_in = wwd; W_RFWr_in = wwr; W_Forward_Ready_in = wrdy;
        We = 1'b1; Reg_Rst = 1'b0; DAck = 1'($urandom); DRData = $urandom;
        tick();
        We = 1'b0; DAck = 1'b0;
        if (lg) begin
            for (int i = 0; i <= d; i++) begin
                // Load enable, flush and a fresh instruction must all be ignored while stalled
                DAck    = (i == d);
                DRData  = (i == d) ? word : $urandom;
                We      = 1'($urandom);
                Reg_Rst = ($urandom_range(0, 3) == 0);
                IR_in   = $urandom;
                tick();
            end
            DAck = 1'b0; We = 1'b0; Reg_Rst = 1'b0;
        end
        for (int i = $urandom_range(0, 2); i > 0; i--) begin
            DAck = 1'($urandom);
            tick();
        end
        DAck = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit          mon_en    = 0;
    logic        prev_dreq = 1'b0;
    int          req_cnt   = 0;
    int          busy_cnt  = 0;
    logic [31:0] last_pc   = 32'd0;
    bus_exp_t    cur_bus;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (DReq && !prev_dreq) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", 32'(DReq), 32'd0);
                    cur_bus.addr = DAddr; cur_bus.we = DWe; cur_bus.be = DByteEn;
                    cur_bus.wdata = DWData; cur_bus.cycles = 0;
                end else begin
                    cur_bus = bus_q.pop_front();
                end
                req_cnt = 1;
            end else if (DReq) begin
                req_cnt++;
            end
            if (DReq) begin
                check("bus_addr", DAddr, cur_bus.addr);
                check("bus_we", 32'(DWe), 32'(cur_bus.we));
                if (cur_bus.we) begin
                    check("bus_byteen", 32'(DByteEn), 32'(cur_bus.be));
                    check("bus_wdata", DWData, cur_bus.wdata);
                end
            end
            if (!DReq && prev_dreq) check("bus_req_cycles", 32'(req_cnt), 32'(cur_bus.cycles));
            prev_dreq = DReq;

            if (Busy_out) begin
                busy_cnt++;
                if (IR_out[31:29] == 3'b100) check("load_ready_while_busy", 32'(M_Forward_Ready_out), 32'd0);
            end
            if (Rst) busy_cnt = 0;

            if (!Busy_out && IR_out != 32'd0 && PC_out != last_pc) begin
                res_exp_t r;
                last_pc = PC_out;
                if (res_q.size() == 0) begin
                    check("res_unexpected", IR_out, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    check("ir", IR_out, r.ir);
                    check("adel", 32'(AdEL_out), 32'(r.adel));
                    check("ades", 32'(AdES_out), 32'(r.ades));
                    check("rfwr", 32'(M_RFWr_out), 32'(r.rfwr));
                    check("rfa3", 32'(M_RFA3_out), 32'(r.rfa3));
                    check("busy_cycles", 32'(busy_cnt), 32'(r.busy_cycles));
                    if (r.chk_data)  check("load_data", LoadData_out, r.load_data);
                    if (r.chk_wd)    check("rfwd", M_RFWD_out, r.rfwd);
                    if (r.chk_ready) check("fwd_ready", 32'(M_Forward_Ready_out), 32'd1);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Reg_Rst = 1'b0; We = 1'b1;
        IR_in = 32'h8C22_0100; PC_in = 32'h1234; Y_in = 32'h100; V2_in = 32'h5;
        W_RFA3_in = 5'd0; W_RFWD_in = 32'd0; W_RFWr_in = 1'b0; W_Forward_Ready_in = 1'b0;
        DAck = 1'b0; DRData = 32'd0;
        tick(); tick();
        Rst = 1'b0; We = 1'b0;
        check("rst_ir", IR_out, 32'd0);
        check("rst_pc", PC_out, 32'd0);
        check("rst_y", Y_out, 32'd0);
        check("rst_dreq", 32'(DReq), 32'd0);
        check("rst_busy", 32'(Busy_out), 32'd0);
        check("rst_adel", 32'(AdEL_out), 32'd0);
        check("rst_ades", 32'(AdES_out), 32'd0);
        check("rst_loaddata", LoadData_out, 32'd0);
        check("rst_rfwr", 32'(M_RFWr_out), 32'd0);
        mon_en = 1;

        do_op(K_LW,  5'd5, 5'd0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_LB,  5'd6, 5'd0, 32'h103, 32'h0, 32'h80FF_0000, 2, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_LBU, 5'd6, 5'd0, 32'h103, 32'h0, 32'h80FF_0000, 2, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_LH,  5'd9, 5'd0, 32'h102, 32'h0, 32'h8001_7FFF, 1, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_SH,  5'd7, 5'd0, 32'h102, 32'h1234_ABCD, 32'h0, 1, 5'd3, 32'h9, 1'b1, 1'b1);
        do_op(K_SB,  5'd8, 5'd0, 32'h201, 32'h11, 32'h0, 0, 5'd8, 32'h55, 1'b1, 1'b1);
        do_op(K_SB,  5'd8, 5'd0, 32'h203, 32'h11, 32'h0, 3, 5'd8, 32'h55, 1'b1, 1'b0);
        do_op(K_LW,  5'd4, 5'd0, 32'h101, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_SW,  5'd4, 5'd0, 32'h3000, 32'h77, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_LW,  5'd4, 5'd0, 32'h2FFC, 32'h0, 32'hCAFE_F00D, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_LH,  5'd4, 5'd0, 32'h2FFF, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_ADDU, 5'd2, 5'd12, 32'h0BAD_0001, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_ORI, 5'd13, 5'd0, 32'h0000_F0F0, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        do_op(K_JAL, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);

        // Reset while a request is outstanding: the access is abandoned
        begin
            bus_exp_t b;
            b.addr = 32'h200; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'd0; b.cycles = 3;
            bus_q.push_back(b);
            IR_in = make_ir(K_LW, 5'd3, 5'd0, 16'h200); PC_in = pc_next; Y_in = 32'h200;
            pc_next += 4;
            We = 1'b1;
            tick();
            We = 1'b0; DAck = 1'b0;
            tick(); tick();
            Rst = 1'b1;
            tick();
            Rst = 1'b0;
            check("abort_dreq", 32'(DReq), 32'd0);
            check("abort_ir", IR_out, 32'd0);
            check("abort_busy", 32'(Busy_out), 32'd0);
            DAck = 1'b1; DRData = 32'hFFFF_FFFF;
            tick();
            DAck = 1'b0;
            check("late_ack_dreq", 32'(DReq), 32'd0);
            check("late_ack_busy", 32'(Busy_out), 32'd0);
            check("late_ack_loaddata", LoadData_out, 32'd0);
        end

        do_op(K_ORI, 5'd10, 5'd0, 32'h42, 32'h0, 32'h0, 0, 5'd0, 32'd0, 1'b0, 1'b0);
        // Flush outranks load enable when the stage is not stalled
        Reg_Rst = 1'b1; We = 1'b1; IR_in = make_ir(K_ORI, 5'd11, 5'd0, 16'h1); PC_in = 32'hABC0;
        tick();
        Reg_Rst = 1'b0; We = 1'b0;
        check("flush_ir", IR_out, 32'd0);
        check("flush_pc", PC_out, 32'd0);

        for (int n = 0; n < 250; n++) begin
            kind_t       k;
            logic [31:0] addr;
            logic [4:0]  rt, wa3;
            int          sz;
            k    = kind_t'($urandom_range(0, 10));
            sz   = size_of(k);
            addr = ($urandom_range(0, 7) == 0) ? 32'h2FF0 + $urandom_range(0, 31) : $urandom_range(0, 32'h2FFF);
            if (sz != 0 && $urandom_range(0, 3) != 0) addr = addr - (addr % sz);
            rt   = 5'($urandom);
            wa3  = ($urandom_range(0, 1) == 1) ? rt : 5'($urandom);
            do_op(k, rt, 5'($urandom), addr, $urandom, $urandom, $urandom_range(0, 3),
                  wa3, $urandom, 1'($urandom), 1'($urandom));
        end

        tick(); tick(); tick();
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
